// File: rtl/nibble_arb_pkg.sv
// Shared types and defaults for the nibble arbiter.
// Holds the FSM state encoding, requester ID type and timeout default.
package nibble_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef logic src_t;

    localparam int TIMEOUT_DEF = 8;

    function automatic int timer_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/nib_timer.sv
// Idle-cycle timer for an in-flight byte.
// Flags expiry on the cycle whose increment would reach TIMEOUT.
module nib_timer
    import nibble_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int W = timer_width(TIMEOUT);
    localparam logic [W-1:0] LIM = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_expired = i_en && (r_cnt == LIM);

endmodule

// File: rtl/nibble_arbiter.sv
// Round-robin arbiter feeding one byte (high then low nibble) at a time
// from two nibble requesters into the packer data path.
module nibble_arbiter
    import nibble_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0_VALID,
    input  logic [3:0] REQ0_DATA,
    output logic       REQ0_READY,
    input  logic       REQ1_VALID,
    input  logic [3:0] REQ1_DATA,
    output logic       REQ1_READY,
    output logic [3:0] PK_DATA,
    output logic       EN_H,
    output logic       EN_L,
    output logic       OUTPUT_VALID,
    output logic       OUT_SRC,
    output logic       TIMEOUT_ERR
);

    state_t r_state;
    state_t w_next;
    src_t   r_grant;
    src_t   w_pick;
    logic   w_any;
    logic   w_valid;
    logic   w_busy;
    logic   w_xfer;
    logic   w_expired;

    assign w_any   = REQ0_VALID || REQ1_VALID;
    assign w_pick  = (REQ0_VALID && REQ1_VALID) ? ~r_grant : REQ1_VALID;
    assign w_valid = r_grant ? REQ1_VALID : REQ0_VALID;
    assign w_busy  = (r_state == S_HIGH) || (r_state == S_LOW);
    assign w_xfer  = w_busy && w_valid;

    nib_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .i_clk     (CLK),
        .i_rst     (RESET),
        .i_clr     ((r_state == S_IDLE) || w_xfer),
        .i_en      (w_busy && !w_xfer),
        .o_expired (w_expired)
    );

    // r_grant doubles as the last-granted pointer; resetting it to 1
    // makes requester 0 win the first contended grant.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_grant <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_any) begin
                r_grant <= w_pick;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_any) w_next = S_HIGH;
            S_HIGH: begin
                if (w_xfer)         w_next = S_LOW;
                else if (w_expired) w_next = S_IDLE;
            end
            S_LOW: begin
                if (w_xfer)         w_next = S_DONE;
                else if (w_expired) w_next = S_IDLE;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        REQ0_READY   = 1'b0;
        REQ1_READY   = 1'b0;
        PK_DATA      = 4'h0;
        EN_H         = 1'b0;
        EN_L         = 1'b0;
        OUTPUT_VALID = 1'b0;
        OUT_SRC      = 1'b0;
        TIMEOUT_ERR  = 1'b0;
        if (!RESET) begin
            if (w_busy) begin
                REQ0_READY  = !r_grant;
                REQ1_READY  = r_grant;
                PK_DATA     = r_grant ? REQ1_DATA : REQ0_DATA;
                EN_H        = (r_state == S_HIGH) && w_valid;
                EN_L        = (r_state == S_LOW) && w_valid;
                TIMEOUT_ERR = w_expired;
            end
            if (r_state == S_DONE) begin
                OUTPUT_VALID = 1'b1;
                OUT_SRC      = r_grant;
            end
        end
    end

endmodule

// File: tb/tb_nibble_arbiter.sv
// Directed bench for nibble_arbiter with a packer model and byte scoreboard.
module tb_nibble_arbiter;
    import nibble_arb_pkg::*;

    localparam int T = 8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       REQ0_VALID, REQ1_VALID;
    logic [3:0] REQ0_DATA, REQ1_DATA;
    logic       REQ0_READY, REQ1_READY;
    logic [3:0] PK_DATA;
    logic       EN_H, EN_L, OUTPUT_VALID, OUT_SRC, TIMEOUT_ERR;

    always #5 CLK = ~CLK;

    nibble_arbiter #(.TIMEOUT(T)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .REQ0_VALID   (REQ0_VALID),
        .REQ0_DATA    (REQ0_DATA),
        .REQ0_READY   (REQ0_READY),
        .REQ1_VALID   (REQ1_VALID),
        .REQ1_DATA    (REQ1_DATA),
        .REQ1_READY   (REQ1_READY),
        .PK_DATA      (PK_DATA),
        .EN_H         (EN_H),
        .EN_L         (EN_L),
        .OUTPUT_VALID (OUTPUT_VALID),
        .OUT_SRC      (OUT_SRC),
        .TIMEOUT_ERR  (TIMEOUT_ERR)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ov_cnt = 0;
    int err_cnt = 0;
    int ov_cyc = -1;
    int err_cyc = -1;
    logic [3:0] pk_hi = 4'h0;
    logic [3:0] pk_lo = 4'h0;
    logic [8:0] sb[$];
    logic       src_log[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cnt_loop();
        forever begin
            @(posedge CLK);
            cyc++;
        end
    endtask

    // Packer model plus per-cycle invariants, sampled mid-cycle.
    task automatic mon_loop();
        logic [8:0] e;
        forever begin
            @(negedge CLK);
            chk("en_excl", {31'd0, EN_H & EN_L}, 0);
            chk("rdy_excl", {31'd0, REQ0_READY & REQ1_READY}, 0);
            chk("src_when_idle", {31'd0, OUT_SRC & ~OUTPUT_VALID}, 0);
            chk("ov_err_excl", {31'd0, OUTPUT_VALID & TIMEOUT_ERR}, 0);
            if (EN_H) pk_hi = PK_DATA;
            if (EN_L) pk_lo = PK_DATA;
            if (TIMEOUT_ERR) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (OUTPUT_VALID) begin
                ov_cnt++;
                ov_cyc = cyc;
                src_log.push_back(OUT_SRC);
                chk("sb_nonempty", {31'd0, sb.size() > 0}, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("byte", {23'd0, OUT_SRC, pk_hi, pk_lo}, {23'd0, e});
                end
            end
        end
    endtask

    function automatic logic rdy(input logic r);
        return r ? REQ1_READY : REQ0_READY;
    endfunction

    task automatic put_nibble(input logic r, input logic [3:0] d,
                              input logic hi);
        bit ok = 0;
        if (r) begin
            REQ1_VALID = 1'b1;
            REQ1_DATA  = d;
        end else begin
            REQ0_VALID = 1'b1;
            REQ0_DATA  = d;
        end
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            if (rdy(r)) begin
                ok = 1;
                break;
            end
        end
        chk("ready_seen", {31'd0, ok}, 1);
        if (ok) begin
            chk("pk_data", {28'd0, PK_DATA}, {28'd0, d});
            chk(hi ? "en_h" : "en_l", {31'd0, hi ? EN_H : EN_L}, 1);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic put_byte(input logic r, input logic [7:0] b);
        put_nibble(r, b[7:4], 1'b1);
        put_nibble(r, b[3:0], 1'b0);
        sb.push_back({r, b});
    endtask

    task automatic wait_ov(input int n);
        for (int i = 0; i < 40; i++) begin
            if (ov_cnt >= n) break;
            @(posedge CLK);
            #1;
        end
        chk("ov_count", ov_cnt, n);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [10:0] outs();
        return {REQ0_READY, REQ1_READY, PK_DATA, EN_H, EN_L,
                OUTPUT_VALID, OUT_SRC, TIMEOUT_ERR};
    endfunction

    initial begin
        int c0, e0, o0;
        RESET      = 1'b1;
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        REQ0_DATA  = 4'h0;
        REQ1_DATA  = 4'h0;
        fork
            cnt_loop();
            mon_loop();
        join_none
        idle(2);
        chk("reset_outs", {21'd0, outs()}, 0);
        RESET = 1'b0;
        idle(1);

        // Single byte A5 from requester 0, latency check.
        c0 = cyc;
        REQ0_VALID = 1'b1;
        REQ0_DATA  = 4'hA;
        @(negedge CLK);
        chk("idle_no_ready", {30'd0, REQ0_READY, REQ1_READY}, 0);
        put_byte(1'b0, 8'hA5);
        REQ0_VALID = 1'b0;
        wait_ov(1);
        chk("latency", ov_cyc - c0, 3);
        idle(2);

        // Requester 1 stalls after the high nibble until timeout.
        e0 = err_cnt;
        o0 = ov_cnt;
        put_nibble(1'b1, 4'h3, 1'b1);
        REQ1_VALID = 1'b0;
        c0 = cyc;
        idle(T + 3);
        chk("timeout_pulse", err_cnt - e0, 1);
        chk("timeout_cycle", err_cyc, c0 + T - 1);
        chk("timeout_no_ov", ov_cnt, o0);

        // Both requesters streaming: grants alternate starting at 0.
        src_log.delete();
        o0 = ov_cnt;
        fork
            begin
                put_byte(1'b0, 8'h12);
                put_byte(1'b0, 8'h34);
                REQ0_VALID = 1'b0;
            end
            begin
                put_byte(1'b1, 8'h9C);
                put_byte(1'b1, 8'hDE);
                REQ1_VALID = 1'b0;
            end
        join
        wait_ov(o0 + 4);
        chk("alt_len", src_log.size(), 4);
        if (src_log.size() == 4) begin
            chk("alt_0", {31'd0, src_log[0]}, 0);
            chk("alt_1", {31'd0, src_log[1]}, 1);
            chk("alt_2", {31'd0, src_log[2]}, 0);
            chk("alt_3", {31'd0, src_log[3]}, 1);
        end
        idle(2);

        // Low nibble lands on the would-expire cycle: transfer wins.
        e0 = err_cnt;
        o0 = ov_cnt;
        put_nibble(1'b0, 4'h7, 1'b1);
        REQ0_VALID = 1'b0;
        idle(T - 1);
        put_nibble(1'b0, 4'hE, 1'b0);
        sb.push_back({1'b0, 8'h7E});
        REQ0_VALID = 1'b0;
        wait_ov(o0 + 1);
        chk("expiry_no_err", err_cnt, e0);
        idle(2);

        // Reset in LOW after a requester-0 grant, then contention.
        put_nibble(1'b0, 4'h5, 1'b1);
        REQ0_VALID = 1'b0;
        e0 = err_cnt;
        o0 = ov_cnt;
        RESET = 1'b1;
        idle(1);
        chk("rst_mid_outs", {21'd0, outs()}, 0);
        RESET = 1'b0;
        src_log.delete();
        fork
            begin
                put_byte(1'b0, 8'h1F);
                REQ0_VALID = 1'b0;
            end
            begin
                put_byte(1'b1, 8'h2B);
                REQ1_VALID = 1'b0;
            end
        join
        wait_ov(o0 + 2);
        chk("rst_first_src", {31'd0, src_log[0]}, 0);
        idle(T + 2);
        chk("rst_no_err", err_cnt, e0);
        chk("rst_ov_total", ov_cnt, o0 + 2);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
